// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a DEPTH-entry
// prefetch FIFO toward decode. Redirects flush the FIFO and discard any
// in-flight response. Optional misaligned-target fault handling is
// compiled in with `define FETCH_MISALIGN_EN; without it the low two
// bits of redirect_pc are ignored and fetch_fault stays 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [2:0]    DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT, DROP, FAULT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [2:0]    count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic          fault_q, fault_d;
    logic [31:0]   buf_instr_q [DEPTH];
    logic [31:0]   buf_instr_d [DEPTH];
    logic [31:0]   buf_pc_q    [DEPTH];
    logic [31:0]   buf_pc_d    [DEPTH];

    logic [31:0]   tgt_pc;
    logic          tgt_bad;
    logic          accept, push, pop;

`ifdef FETCH_MISALIGN_EN
    assign tgt_pc  = redirect_pc;
    assign tgt_bad = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign tgt_pc  = {redirect_pc[31:2], 2'b00};
    assign tgt_bad = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != 3'd0);
    assign instr       = buf_instr_q[head_q];
    assign instr_pc    = buf_pc_q[head_q];
    assign fetch_fault = fault_q;

    // Next-state: FSM, fetch PC, FIFO pointers; redirect overrides everything else.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fault_d     = fault_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        // Requesting only from RUN guarantees count + outstanding <= DEPTH.
        imem_req = (state_q == RUN) && !redirect && (count_q < DEPTH_C) && !rst;
        accept   = imem_req && imem_ready;
        push     = (state_q == WAIT) && imem_rvalid && !redirect;
        pop      = instr_valid && instr_ready && !redirect;

        if (redirect) begin
            count_d    = 3'd0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = tgt_pc;
            fault_d    = tgt_bad;
            case (state_q)
                // Response landing in the redirect cycle is dropped and closes the
                // outstanding slot; otherwise wait it out in DROP.
                WAIT, DROP: state_d = imem_rvalid ? (tgt_bad ? FAULT : RUN) : DROP;
                default:    state_d = tgt_bad ? FAULT : RUN;
            endcase
        end else begin
            case (state_q)
                RUN: if (accept) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
                WAIT:    if (imem_rvalid) state_d = RUN;
                // fault_q doubles as the "fault after drain" marker.
                DROP:    if (imem_rvalid) state_d = fault_q ? FAULT : RUN;
                default: ;
            endcase
            if (push) begin
                buf_instr_d[tail_q] = imem_rdata;
                buf_pc_d[tail_q]    = req_pc_q;
                tail_d              = ptr_inc(tail_q);
            end
            if (pop) head_d = ptr_inc(head_q);
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= 3'd0;
            head_q     <= '0;
            tail_q     <= '0;
            fault_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_q[i] <= 32'd0;
                buf_pc_q[i]    <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fault_q     <= fault_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic for fetch_unit,
// checked against a queue-based model of the fetch stream. Honours
// FETCH_MISALIGN_EN when defined for the build.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: buffered PCs in order, next fetch address, fault flag,
    // and the single memory transaction in flight.
    logic [31:0] mq[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    logic        m_fault = 1'b0;
    logic        pend = 1'b0;
    logic        live = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_lat = 0;
    int          lat_fix = 0;

    // Observed DUT activity for the directed scenarios.
    logic [31:0] seen_pc[$];
    logic [31:0] acc_pc[$];
    logic        obs_req, obs_valid, obs_fault;
    logic [31:0] obs_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_q(input string tag, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
        if (idx < q.size()) chk(tag, q[idx], exp);
        else chk({tag, "_count"}, q.size(), idx + 1);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc,
                         input logic ir, input logic dr);
        logic rv, exp_req;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; redirect = rd; redirect_pc = rpc; imem_ready = ir; instr_ready = dr;
        rv = pend && (pend_lat == 0) && !r;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend_addr) : $urandom;
        #1;
        exp_req = !r && !rd && !pend && !m_fault && (mq.size() < DEPTH);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
        chk("instr_valid", instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("instr_pc", instr_pc, mq[0]);
            chk("instr", instr, mem_word(mq[0]));
        end
        chk("fetch_fault", fetch_fault, m_fault);
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid; obs_fault = fetch_fault;
        if (imem_req && ir) acc_pc.push_back(imem_addr);
        if (instr_valid && dr && !rd && !r) seen_pc.push_back(instr_pc);

        if (pend && !rv && pend_lat > 0) pend_lat--;
        if (r) begin
            mq.delete(); pend = 1'b0; live = 1'b0;
            m_fetch_pc = RESET_PC; m_fault = 1'b0;
        end else if (rd) begin
            mq.delete();
            tgt = rpc;
`ifdef FETCH_MISALIGN_EN
            m_fault = (rpc[1:0] != 2'b00);
`else
            tgt[1:0] = 2'b00;
`endif
            m_fetch_pc = tgt;
            if (rv) pend = 1'b0;
            else live = 1'b0;
        end else begin
            if (mq.size() > 0 && dr) void'(mq.pop_front());
            if (rv) begin
                if (live) mq.push_back(pend_addr);
                pend = 1'b0;
            end
            if (exp_req && ir) begin
                pend = 1'b1; live = 1'b1; pend_addr = m_fetch_pc;
                pend_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        seen_pc.delete(); acc_pc.delete();
    endtask

    initial begin
        // Back-to-back sequential fetch.
        lat_fix = 0;
        do_reset();
        chk("rst_valid", obs_valid, 1'b0);
        chk("rst_req", obs_req, 1'b0);
        chk("rst_fault", obs_fault, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) chk_q("seq_pc", seen_pc, i, 32'(4 * i));

        // Decode stalled: DEPTH requests then quiet until a pop.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("full_nreq", acc_pc.size(), DEPTH);
        chk_q("full_a0", acc_pc, 0, 32'h0);
        chk_q("full_a1", acc_pc, 1, 32'h4);
        chk("full_req_low", obs_req, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk_q("refill_a2", acc_pc, 2, 32'h8);

        // Redirect while the request to 8 is outstanding.
        lat_fix = 2;
        do_reset();
        for (int i = 0; i < 30 && !(acc_pc.size() > 0 && acc_pc[acc_pc.size()-1] == 32'h8); i++)
            cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk_q("drop_acc8", acc_pc, 2, 32'h8);
        seen_pc.delete();
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk_q("drop_next", seen_pc, 0, 32'h100);
        chk_q("drop_next2", seen_pc, 1, 32'h104);

        // Address wrap.
        lat_fix = 0;
        acc_pc.delete(); seen_pc.delete();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk_q("wrap_a0", acc_pc, 0, 32'hFFFF_FFFC);
        chk_q("wrap_a1", acc_pc, 1, 32'h0);
        chk_q("wrap_pc1", seen_pc, 1, 32'h0);

        // Misaligned redirect target.
        acc_pc.delete();
        cycle(1'b0, 1'b1, 32'h102, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
`ifdef FETCH_MISALIGN_EN
        chk("mis_fault", obs_fault, 1'b1);
        chk("mis_req", obs_req, 1'b0);
        chk("mis_nreq", acc_pc.size(), 0);
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("mis_clear", obs_fault, 1'b0);
        chk_q("mis_a0", acc_pc, 0, 32'h200);
`else
        chk("mis_fault", obs_fault, 1'b0);
        chk_q("mis_a0", acc_pc, 0, 32'h100);
`endif

        // Reset with a request outstanding.
        lat_fix = 3;
        acc_pc.delete();
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
        for (int i = 0; i < 10 && acc_pc.size() == 0; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("rst_out_acc", acc_pc.size(), 1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("rst_out_req", obs_req, 1'b0);
        chk("rst_out_valid", obs_valid, 1'b0);
        chk("rst_out_fault", obs_fault, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("rst_restart_req", obs_req, 1'b1);
        chk("rst_restart_addr", obs_addr, RESET_PC);

        // Randomized traffic.
        lat_fix = -1;
        for (int i = 0; i < 4000; i++) begin
            logic r, rd, ir, dr;
            logic [31:0] rpc;
            r  = ($urandom_range(0, 299) == 0);
            rd = ($urandom_range(0, 9) == 0);
            ir = ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                1:       rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                2:       rpc = $urandom;
                default: rpc = {$urandom, 2'b00};
            endcase
            cycle(r, rd, rpc, ir, dr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
